// File: rtl/regfile_pkg.sv
// Shared register-file constants and the protected-destination filter used by
// both the writeback buffer and the register file write port.
package regfile_pkg;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_K0   = 26;
    localparam int unsigned REG_K1   = 27;
    localparam int unsigned REG_SP   = 29;

    // Destinations that never accept a writeback ($zero and the kernel temps).
    function automatic logic is_protected(input int unsigned addr);
        return (addr == REG_ZERO) || (addr == REG_K0) || (addr == REG_K1);
    endfunction

endpackage

// File: rtl/wb_entry_search.sv
// Newest-first forwarding search across the pending queue entries, falling back
// to the registered output stage when no queued entry matches.
module wb_entry_search
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic [ADDR_W-1:0]          lookup_reg_i,
    input  logic [ADDR_W-1:0]          entry_addr_i [DEPTH],
    input  logic [DATA_W-1:0]          entry_data_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head_i,
    input  logic [$clog2(DEPTH+1)-1:0] count_i,
    input  logic                       out_we_i,
    input  logic [ADDR_W-1:0]          out_addr_i,
    input  logic [DATA_W-1:0]          out_data_i,
    output logic                       hit_o,
    output logic [DATA_W-1:0]          data_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Walk oldest to newest so a later (newer) match overrides earlier ones;
    // the output stage is written first and thus has the lowest priority.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        if (lookup_reg_i != ADDR_W'(REG_ZERO)) begin
            if (out_we_i && (out_addr_i == lookup_reg_i)) begin
                hit_o  = 1'b1;
                data_o = out_data_i;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx = head_i + PTR_W'(i);
                if ((i < 32'(count_i)) && (entry_addr_i[idx] == lookup_reg_i)) begin
                    hit_o  = 1'b1;
                    data_o = entry_data_i[idx];
                end
            end
        end
    end

endmodule

// File: rtl/writeback_buffer.sv
// In-order writeback queue merging the load and ALU result paths onto a single
// registered register-file write port, with forwarding of pending values.
module writeback_buffer
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       MemValid,
    input  logic [ADDR_W-1:0]          MemAddr,
    input  logic [DATA_W-1:0]          MemData,
    output logic                       MemReady,
    input  logic                       AluValid,
    input  logic [ADDR_W-1:0]          AluAddr,
    input  logic [DATA_W-1:0]          AluData,
    output logic                       AluReady,
    output logic                       RegWrite,
    output logic [ADDR_W-1:0]          WAddr,
    output logic [DATA_W-1:0]          WData,
    input  logic [ADDR_W-1:0]          LookupReg,
    output logic                       LookupHit,
    output logic [DATA_W-1:0]          LookupData,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       Full,
    output logic                       Empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [PTR_W-1:0]  head_q,  head_d;
    logic [PTR_W-1:0]  tail_q,  tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              we_q,    we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [CNT_W-1:0]  free;
    logic              mem_keep, alu_keep, pop;
    logic [PTR_W-1:0]  alu_slot;

    // Acceptance is based on occupancy at cycle start only; a dropped
    // (protected) load does not shift the ALU entry's slot.
    always_comb begin
        free     = CNT_W'(DEPTH) - count_q;
        MemReady = (free != '0);
        AluReady = MemValid ? (free >= CNT_W'(2)) : (free != '0);
        mem_keep = MemValid && MemReady && !is_protected(32'(MemAddr));
        alu_keep = AluValid && AluReady && !is_protected(32'(AluAddr));
        pop      = (count_q != '0);
        alu_slot = tail_q + PTR_W'(mem_keep);
        head_d   = head_q + PTR_W'(pop);
        tail_d   = tail_q + PTR_W'(mem_keep) + PTR_W'(alu_keep);
        count_d  = count_q + CNT_W'(mem_keep) + CNT_W'(alu_keep) - CNT_W'(pop);
    end

    // Output stage: present the popped head, otherwise drop the enable and hold.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (pop) begin
            we_d    = 1'b1;
            waddr_d = addr_q[head_q];
            wdata_d = data_q[head_q];
        end
    end

    // Control state and output stage; reset discards every pending entry.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Entry storage; contents beyond Count are never observed, so no reset.
    always_ff @(posedge Clk) begin
        if (mem_keep) begin
            addr_q[tail_q] <= MemAddr;
            data_q[tail_q] <= MemData;
        end
        if (alu_keep) begin
            addr_q[alu_slot] <= AluAddr;
            data_q[alu_slot] <= AluData;
        end
    end

    wb_entry_search #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_search (
        .lookup_reg_i (LookupReg),
        .entry_addr_i (addr_q),
        .entry_data_i (data_q),
        .head_i       (head_q),
        .count_i      (count_q),
        .out_we_i     (we_q),
        .out_addr_i   (waddr_q),
        .out_data_i   (wdata_q),
        .hit_o        (LookupHit),
        .data_o       (LookupData)
    );

    assign RegWrite = we_q;
    assign WAddr    = waddr_q;
    assign WData    = wdata_q;
    assign Count    = count_q;
    assign Full     = (count_q == CNT_W'(DEPTH));
    assign Empty    = (count_q == '0);

    a_count_bound: assert property (@(posedge Clk) disable iff (Rst) count_q <= CNT_W'(DEPTH));

endmodule
